// File: rtl/neighbor_expand.sv
// Expands one grid node into its in-bounds, wall-free, not-yet-closed neighbours,
// walking N, E, S, W and handing each survivor to the open list one at a time.
//
// Handshakes: srch_req/srch_x/srch_y are held until the cycle srch_ack=1 and drop on
// the following cycle; nb_valid/nb_x/nb_y are held until the cycle nb_ready=1, which
// is the transfer cycle. The two requests are never high together.
module neighbor_expand #(
   parameter int unsigned GRID_W  = 20,
   parameter int unsigned GRID_H  = 20,
   parameter int unsigned COORD_W = 8
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               start,
   input  logic [COORD_W-1:0] cur_x,
   input  logic [COORD_W-1:0] cur_y,
   output logic               busy,
   output logic               done,
   output logic [COORD_W-1:0] wall_x,
   output logic [COORD_W-1:0] wall_y,
   input  logic               wall_hit,
   output logic               srch_req,
   output logic [COORD_W-1:0] srch_x,
   output logic [COORD_W-1:0] srch_y,
   input  logic               srch_ack,
   input  logic               srch_found,
   output logic               nb_valid,
   output logic [COORD_W-1:0] nb_x,
   output logic [COORD_W-1:0] nb_y,
   input  logic               nb_ready,
   output logic [2:0]         nb_count
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GEN    = 3'd1,
      WALL   = 3'd2,
      SEARCH = 3'd3,
      EMIT   = 3'd4,
      NEXT   = 3'd5,
      DONE   = 3'd6
   } state_t;

   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);
   localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);

   state_t             state;
   logic [1:0]         dir;
   logic [COORD_W-1:0] node_x;
   logic [COORD_W-1:0] node_y;

   logic [COORD_W-1:0] cand_x;
   logic [COORD_W-1:0] cand_y;
   logic               cand_oob;

   // Bounds are decided first; the +/-1 is only applied to an in-bounds side, so it never wraps.
   always_comb begin
      cand_x   = node_x;
      cand_y   = node_y;
      cand_oob = 1'b0;
      case (dir)
         2'd0: begin
            cand_oob = (node_y == '0);
            if (!cand_oob) cand_y = node_y - ONE;
         end
         2'd1: begin
            cand_oob = (node_x >= X_MAX);
            if (!cand_oob) cand_x = node_x + ONE;
         end
         2'd2: begin
            cand_oob = (node_y >= Y_MAX);
            if (!cand_oob) cand_y = node_y + ONE;
         end
         default: begin
            cand_oob = (node_x == '0);
            if (!cand_oob) cand_x = node_x - ONE;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         dir      <= 2'd0;
         node_x   <= '0;
         node_y   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         wall_x   <= '0;
         wall_y   <= '0;
         srch_req <= 1'b0;
         srch_x   <= '0;
         srch_y   <= '0;
         nb_valid <= 1'b0;
         nb_x     <= '0;
         nb_y     <= '0;
         nb_count <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  node_x   <= cur_x;
                  node_y   <= cur_y;
                  dir      <= 2'd0;
                  nb_count <= 3'd0;
                  busy     <= 1'b1;
                  state    <= GEN;
               end
            end
            GEN: begin
               if (cand_oob) begin
                  state <= NEXT;
               end else begin
                  wall_x <= cand_x;
                  wall_y <= cand_y;
                  state  <= WALL;
               end
            end
            WALL: begin
               // wall_x/wall_y already hold the candidate, so wall_hit answers for it now.
               if (wall_hit) begin
                  state <= NEXT;
               end else begin
                  srch_req <= 1'b1;
                  srch_x   <= wall_x;
                  srch_y   <= wall_y;
                  state    <= SEARCH;
               end
            end
            SEARCH: begin
               if (srch_ack) begin
                  srch_req <= 1'b0;
                  if (srch_found) begin
                     state <= NEXT;
                  end else begin
                     nb_valid <= 1'b1;
                     nb_x     <= srch_x;
                     nb_y     <= srch_y;
                     state    <= EMIT;
                  end
               end
            end
            EMIT: begin
               if (nb_ready) begin
                  nb_valid <= 1'b0;
                  nb_count <= nb_count + 3'd1;
                  state    <= NEXT;
               end
            end
            NEXT: begin
               if (dir == 2'd3) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  dir   <= dir + 2'd1;
                  state <= GEN;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               done     <= 1'b0;
               srch_req <= 1'b0;
               nb_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_neighbor_expand.sv
// Bench for neighbor_expand: directed corner cases plus randomized maps, checked
// against an arithmetic neighbour model and an expected-emission queue.
module tb_neighbor_expand;

   localparam int GW = 20;
   localparam int GH = 20;
   localparam int CW = 8;

   logic          Clk;
   logic          Reset;
   logic          start;
   logic [CW-1:0] cur_x;
   logic [CW-1:0] cur_y;
   logic          busy;
   logic          done;
   logic [CW-1:0] wall_x;
   logic [CW-1:0] wall_y;
   logic          wall_hit;
   logic          srch_req;
   logic [CW-1:0] srch_x;
   logic [CW-1:0] srch_y;
   logic          srch_ack;
   logic          srch_found;
   logic          nb_valid;
   logic [CW-1:0] nb_x;
   logic [CW-1:0] nb_y;
   logic          nb_ready;
   logic [2:0]    nb_count;

   neighbor_expand #(.GRID_W(GW), .GRID_H(GH), .COORD_W(CW)) dut (
      .Clk(Clk), .Reset(Reset), .start(start), .cur_x(cur_x), .cur_y(cur_y),
      .busy(busy), .done(done), .wall_x(wall_x), .wall_y(wall_y), .wall_hit(wall_hit),
      .srch_req(srch_req), .srch_x(srch_x), .srch_y(srch_y), .srch_ack(srch_ack),
      .srch_found(srch_found), .nb_valid(nb_valid), .nb_x(nb_x), .nb_y(nb_y),
      .nb_ready(nb_ready), .nb_count(nb_count)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   logic wall_map   [GH][GW];
   logic closed_map [GH][GW];

   assign wall_hit = (int'(wall_x) < GW && int'(wall_y) < GH) ? wall_map[int'(wall_y)][int'(wall_x)] : 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] exp_q[$];
   logic [15:0] exp_v;

   int srch_max  = 0;
   int hold_max  = 0;
   bit rand_mode = 1'b0;
   int done_cnt  = 0;
   int srch_cnt  = 0;
   int xfer_cnt  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_maps();
      for (int y = 0; y < GH; y++)
         for (int x = 0; x < GW; x++) begin
            wall_map[y][x]   = 1'b0;
            closed_map[y][x] = 1'b0;
         end
   endtask

   // Reference: a neighbour is searched if on-grid and not a wall, emitted if also not closed.
   task automatic build_expected(input int x, input int y, output int n_srch);
      int dx[4];
      int dy[4];
      int nx;
      int ny;
      dx = '{0, 1, 0, -1};
      dy = '{-1, 0, 1, 0};
      n_srch = 0;
      exp_q.delete();
      for (int d = 0; d < 4; d++) begin
         nx = x + dx[d];
         ny = y + dy[d];
         if (nx >= 0 && nx < GW && ny >= 0 && ny < GH && !wall_map[ny][nx]) begin
            n_srch++;
            if (!closed_map[ny][nx]) exp_q.push_back({8'(nx), 8'(ny)});
         end
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_srch_req"}, 32'(srch_req), 0);
      check({tag, "_nb_valid"}, 32'(nb_valid), 0);
      check({tag, "_nb_count"}, 32'(nb_count), 0);
      check({tag, "_wall_xy"}, 32'({wall_x, wall_y}), 0);
      check({tag, "_srch_xy"}, 32'({srch_x, srch_y}), 0);
      check({tag, "_nb_xy"}, 32'({nb_x, nb_y}), 0);
   endtask

   // Responders and monitor: decide srch_ack/nb_ready for the coming edge and log traffic.
   logic          p_req;
   logic          p_val;
   logic [CW-1:0] p_sx, p_sy, p_nx, p_ny;
   int            s_wait, n_wait, cur_delay, cur_hold;

   always @(negedge Clk) begin
      if (Reset) begin
         srch_ack   = 1'b0;
         srch_found = 1'b0;
         nb_ready   = 1'b0;
         p_req      = 1'b0;
         p_val      = 1'b0;
         s_wait     = 0;
         n_wait     = 0;
      end else begin
         check("one_in_flight", 32'(srch_req & nb_valid), 0);
         if (busy) check("wall_in_grid", 32'(int'(wall_x) < GW && int'(wall_y) < GH), 1);
         if (srch_req) begin
            if (!p_req) begin
               srch_cnt++;
               s_wait    = 0;
               cur_delay = rand_mode ? int'($urandom_range(0, srch_max)) : srch_max;
            end else begin
               check("srch_stable", 32'({srch_x, srch_y}), 32'({p_sx, p_sy}));
            end
            if (s_wait >= cur_delay) begin
               srch_ack   = 1'b1;
               srch_found = (int'(srch_x) < GW && int'(srch_y) < GH) ?
                            closed_map[int'(srch_y)][int'(srch_x)] : 1'b0;
            end else begin
               srch_ack   = 1'b0;
               srch_found = 1'($urandom_range(0, 1));
            end
            s_wait++;
         end else begin
            srch_ack   = 1'b0;
            srch_found = 1'b0;
         end
         if (nb_valid) begin
            if (!p_val) begin
               n_wait   = 0;
               cur_hold = rand_mode ? int'($urandom_range(0, hold_max)) : hold_max;
            end else begin
               check("nb_stable", 32'({nb_x, nb_y}), 32'({p_nx, p_ny}));
            end
            if (n_wait >= cur_hold) begin
               nb_ready = 1'b1;
               xfer_cnt++;
               if (exp_q.size() == 0) begin
                  check("nb_extra", 32'({nb_x, nb_y}), 32'hffff_ffff);
               end else begin
                  exp_v = exp_q.pop_front();
                  check("nb_xy", 32'({nb_x, nb_y}), 32'(exp_v));
               end
            end else begin
               nb_ready = 1'b0;
            end
            n_wait++;
         end else begin
            nb_ready = 1'($urandom_range(0, 1));
         end
         if (done) done_cnt++;
         p_req = srch_req;
         p_val = nb_valid;
         p_sx  = srch_x;
         p_sy  = srch_y;
         p_nx  = nb_x;
         p_ny  = nb_y;
      end
   end

   task automatic run_expand(input int x, input int y, input bit poke_busy, input bit poke_done);
      int exp_srch;
      int exp_n;
      int cyc;
      build_expected(x, y, exp_srch);
      exp_n    = exp_q.size();
      done_cnt = 0;
      srch_cnt = 0;
      xfer_cnt = 0;
      @(negedge Clk);
      cur_x = CW'(x);
      cur_y = CW'(y);
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      check("busy_after_start", 32'(busy), 1);
      if (poke_busy) begin
         repeat (2) @(negedge Clk);
         start = 1'b1;
         cur_x = 8'd0;
         cur_y = 8'd0;
         @(negedge Clk);
         start = 1'b0;
      end
      cyc = 0;
      while (!done && cyc < 2000) begin
         @(negedge Clk);
         cyc++;
      end
      check("done_seen", 32'(done), 1);
      if (poke_done) begin
         start = 1'b1;
         cur_x = 8'd7;
         cur_y = 8'd7;
      end
      @(negedge Clk);
      start = 1'b0;
      check("done_one_cycle", 32'(done), 0);
      check("idle_after_done", 32'(busy), 0);
      check("nb_count", 32'(nb_count), 32'(exp_n));
      check("emit_total", 32'(xfer_cnt), 32'(exp_n));
      check("exp_q_drained", 32'(exp_q.size()), 0);
      check("search_total", 32'(srch_cnt), 32'(exp_srch));
      check("done_pulses", 32'(done_cnt), 1);
      if (poke_done) begin
         @(negedge Clk);
         check("start_in_done_ignored", 32'(busy), 0);
         check("count_held", 32'(nb_count), 32'(exp_n));
      end
   endtask

   initial begin
      int cyc;
      int x;
      int y;
      Reset = 1'b1;
      start = 1'b0;
      cur_x = '0;
      cur_y = '0;
      clear_maps();
      #1;
      check_zero("reset");
      repeat (3) @(negedge Clk);
      Reset = 1'b0;

      // Centre, open map, immediate handshakes.
      run_expand(5, 5, 1'b0, 1'b0);

      // Grid corners and edges.
      run_expand(0, 0, 1'b0, 1'b0);
      wall_map[19][18]   = 1'b1;
      closed_map[18][19] = 1'b1;
      run_expand(19, 19, 1'b0, 1'b0);
      clear_maps();
      run_expand(19, 0, 1'b0, 1'b0);
      run_expand(0, 19, 1'b0, 1'b0);

      // Slow search and open list.
      srch_max = 5;
      hold_max = 3;
      run_expand(5, 5, 1'b0, 1'b0);

      // start while busy and during the done cycle.
      run_expand(5, 5, 1'b1, 1'b1);
      srch_max = 0;
      hold_max = 0;

      // Reset with a neighbour waiting on the open list.
      hold_max = 50;
      exp_q.delete();
      @(negedge Clk);
      cur_x = 8'd5;
      cur_y = 8'd5;
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      cyc = 0;
      while (!nb_valid && cyc < 200) begin
         @(negedge Clk);
         cyc++;
      end
      check("nb_valid_before_reset", 32'(nb_valid), 1);
      #2 Reset = 1'b1;
      #1;
      check_zero("mid_reset");
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      check("post_reset_idle", 32'({busy, srch_req, nb_valid}), 0);
      hold_max = 0;
      run_expand(5, 5, 1'b0, 1'b0);

      // Randomized maps, nodes and handshake timing.
      rand_mode = 1'b1;
      srch_max  = 4;
      hold_max  = 3;
      for (int it = 0; it < 30; it++) begin
         clear_maps();
         for (int yy = 0; yy < GH; yy++)
            for (int xx = 0; xx < GW; xx++) begin
               wall_map[yy][xx]   = ($urandom_range(0, 3) == 0);
               closed_map[yy][xx] = ($urandom_range(0, 2) == 0);
            end
         if (it % 3 == 0) begin
            x = $urandom_range(0, 1) ? GW - 1 : 0;
            y = int'($urandom_range(0, GH - 1));
         end else begin
            x = int'($urandom_range(0, GW - 1));
            y = int'($urandom_range(0, GH - 1));
         end
         run_expand(x, y, 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/neighbor_expand.md
NEIGHBOR_EXPAND -- requirements
Module: neighbor_expand

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  GRID_W, 20, grid columns
  GRID_H, 20, grid rows
  COORD_W, 8, coordinate width
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning), clock and reset first:
  Clk  in  1  clock; reset Reset, asynchronous, active-high; clock Clk
  Reset  in  1  asynchronous active-high reset
  start  in  1  request expansion of current node
  cur_x  in  COORD_W  current node column
  cur_y  in  COORD_W  current node row
  busy  out  1  expansion in progress
  done  out  1  one-cycle pulse, expansion finished
  wall_x  out  COORD_W  wall-map query column
  wall_y  out  COORD_W  wall-map query row
  wall_hit  in  1  combinational wall-map answer for wall_x/wall_y
  srch_req  out  1  closed-list search request
  srch_x  out  COORD_W  search key column
  srch_y  out  COORD_W  search key row
  srch_ack  in  1  search complete, srch_found valid
  srch_found  in  1  key present in closed list
  nb_valid  out  1  neighbour available for open list
  nb_x  out  COORD_W  neighbour column
  nb_y  out  COORD_W  neighbour row
  nb_ready  in  1  open list accepts neighbour
  nb_count  out  3  neighbours emitted this expansion (0..4)

Function
REQ-003 States SHALL be IDLE, GEN, WALL, SEARCH, EMIT, NEXT, DONE.
REQ-004 IDLE: start=1 SHALL capture cur_x/cur_y, clear direction index d to 0 and nb_count to 0, and go to GEN; start outside IDLE SHALL be ignored.
REQ-005 Direction order SHALL be d=0 N (y-1), d=1 E (x+1), d=2 S (y+1), d=3 W (x-1).
REQ-006 GEN SHALL form the candidate in one cycle; an out-of-bounds candidate (N at y=0, E at x=GRID_W-1, S at y=GRID_H-1, W at x=0) SHALL go to NEXT, otherwise to WALL.
REQ-007 Candidate arithmetic SHALL be COORD_W unsigned and SHALL never wrap, because bounds are tested before forming the candidate.
REQ-008 WALL SHALL drive wall_x/wall_y with the candidate and sample wall_hit the same cycle; wall_hit=1 SHALL go to NEXT, else to SEARCH.
REQ-009 SEARCH SHALL hold srch_req=1 with stable srch_x/srch_y until the cycle srch_ack=1; srch_found=1 SHALL go to NEXT, else to EMIT; srch_req SHALL deassert the cycle after ack.
REQ-010 EMIT SHALL hold nb_valid=1 with stable nb_x/nb_y until nb_ready=1; on transfer, nb_count SHALL increment and the state SHALL go to NEXT.
REQ-011 NEXT: d=3 SHALL go to DONE; otherwise d SHALL increment and the state SHALL go to GEN.
REQ-012 DONE SHALL assert done for exactly one cycle and return to IDLE; nb_count SHALL hold until the next accepted start.
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 start asserted in the DONE cycle SHALL be ignored; start is accepted only in IDLE.
REQ-015 srch_req and nb_valid SHALL never be high simultaneously; at most one candidate is in flight.
REQ-016 Unused states SHALL recover to IDLE.

Reset
REQ-017 Reset SHALL force IDLE, d=0, and busy, done, srch_req, nb_valid, nb_count, wall_x, wall_y, srch_x, srch_y, nb_x, nb_y all to 0, asynchronously.
REQ-018 Reset mid-operation SHALL abandon the current candidate with no further srch_req or nb_valid, including when srch_req or nb_valid is asserted.

Verification
REQ-019 Centre node (5,5), no walls, all searches not found, nb_ready=1 -> emits (5,4),(6,5),(5,6),(4,5) in order; nb_count=4; one done pulse.
REQ-020 Corner (0,0) -> only E (1,0) and S (0,1) are queried and emitted; nb_count=2; N and W never appear on wall_x/wall_y.
REQ-021 Corner (19,19) with wall at (18,19) and (19,18) found in closed list -> no nb_valid; nb_count=0; done pulses.
REQ-022 srch_ack delayed 5 cycles, nb_ready held low 3 cycles -> srch_x/srch_y and nb_x/nb_y stay stable throughout; no emitted neighbour is lost or duplicated.
REQ-023 Reset asserted while nb_valid=1 -> all outputs 0 immediately; after release, start for (5,5) -> full 4-neighbour sequence from N.
REQ-024 start pulsed while busy or in the DONE cycle -> ignored; captured node is unchanged.
